// File: rtl/lut_const_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lut_const_multiplier                                                     |
// | Signed fixed-point a*b >>> FRAC using a radix-16 multiple table.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lut_const_multiplier #(
   parameter int IN_W    = 32,
   parameter int CONST_W = 26,
   parameter int FRAC    = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [IN_W-1:0] a,
   input  logic [IN_W-1:0] b,
   output logic            out_valid,
   output logic [IN_W-1:0] result
);

   localparam int D  = (CONST_W + 3) / 4;
   localparam int BW = D * 4;
   localparam int LW = IN_W + 4;
   localparam int PW = IN_W + BW;

   logic signed [CONST_W-1:0] b_const;
   logic [IN_W-1:0]           a_d, a_q;
   logic [BW-1:0]             bs_d, bs_q;
   logic                      valid_d, valid_q;
   logic [IN_W-1:0]           result_d, result_q;
   logic                      out_valid_d, out_valid_q;

   logic signed [LW-1:0]      a_ext;
   logic signed [LW-1:0]      lut [16];
   logic [3:0]                digit;
   logic signed [LW-1:0]      pp;
   logic signed [PW-1:0]      prod;

   assign b_const = b[CONST_W-1:0];

   generate
      if (CONST_W < IN_W) begin : g_unused_b
         logic unused_b_hi;
         assign unused_b_hi = ^b[IN_W-1:CONST_W];
      end
   endgenerate

   // Stage 1: capture operand and sign-extended constant
   always_comb begin
      a_d     = a;
      bs_d    = BW'(b_const);
      valid_d = in_valid;
   end

   // Multiples 0..15 of a, each formed from the set bits of k as shifted copies
   always_comb begin
      a_ext = LW'(signed'(a_q));
      for (int k = 0; k < 16; k++) begin
         lut[k] = '0;
         for (int j = 0; j < 4; j++) begin
            if (((k >> j) & 1) != 0) begin
               lut[k] = lut[k] + (a_ext <<< j);
            end
         end
      end
   end

   // Top digit is two's-complement, so values 8..15 stand for k-16
   always_comb begin
      prod  = '0;
      digit = '0;
      pp    = '0;
      for (int i = 0; i < D; i++) begin
         digit = bs_q[4*i +: 4];
         pp    = lut[digit];
         if ((i == D - 1) && digit[3]) begin
            pp = pp - (a_ext <<< 4);
         end
         prod = prod + (PW'(pp) <<< (4 * i));
      end
   end

   always_comb begin
      result_d    = IN_W'(prod >>> FRAC);
      out_valid_d = valid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q         <= '0;
         bs_q        <= '0;
         valid_q     <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         a_q         <= a_d;
         bs_q        <= bs_d;
         valid_q     <= valid_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_const_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lut_const_multiplier                                                  |
// | Directed vectors, streaming and mid-flight reset for the LUT multiplier.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lut_const_multiplier;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic [31:0] result;

   int checks;
   int failures;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [14];
   logic [31:0] exp_q [$];

   lut_const_multiplier #(
      .IN_W    (32),
      .CONST_W (26),
      .FRAC    (15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] p;
      p = 64'(signed'(x)) * 64'(signed'(y[25:0]));
      return p[46:15];
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      vecs[0]  = '{32'd1000,     32'd32768,    32'd1000};
      vecs[1]  = '{32'd1000,     32'd23170,    32'd707};
      vecs[2]  = '{-32'sd1000,   32'd23170,    32'hFFFFFD3C};
      vecs[3]  = '{32'd65536,    32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[4]  = '{-32'sd3,      32'hFFFFFFFF, 32'h00000000};
      vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h00010000};
      vecs[6]  = '{32'h7FFFFFFF, 32'h01FFFFFF, 32'hFFFEFC00};
      vecs[7]  = '{32'd1000,     32'hFC008000, 32'd1000};
      vecs[8]  = '{32'd1000,     32'h03FF8000, 32'hFFFFFC18};
      vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
      vecs[10] = '{32'h00012345, 32'h00010000, 32'h0002468A};
      vecs[11] = '{32'h7FFFFFFF, 32'h00010000, 32'hFFFFFFFE};
      vecs[12] = '{32'h80000000, 32'h02000000, 32'h00000000};
      vecs[13] = '{32'd3,        32'h0000FFFF, 32'd5};

      rst      = 1'b1;
      in_valid = 1'b0;
      a        = 32'd12345;
      b        = 32'd32768;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed vectors: one operation, latency of exactly two edges
      for (int i = 0; i < 14; i++) begin
         a        = vecs[i].a;
         b        = vecs[i].b;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check($sformatf("vec%0d_valid_early", i), {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      end
      @(posedge clk);
      #1;

      // Back-to-back random stream, expected against a full-width reference
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc < 8) begin
            a        = $urandom;
            b        = $urandom;
            in_valid = 1'b1;
            exp_q.push_back(ref_mul(a, b));
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         check($sformatf("stream%0d_valid", cyc), {31'd0, out_valid},
               {31'd0, (cyc >= 1 && cyc <= 8)});
         if (out_valid && exp_q.size() > 0) begin
            check($sformatf("stream%0d_result", cyc), result, exp_q.pop_front());
         end
      end
      check("stream_drained", exp_q.size(), 32'd0);

      // Reset while two operations are in flight
      a        = 32'd1000;
      b        = 32'd32768;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      a = 32'd2000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("inflight_valid", {31'd0, out_valid}, 32'd1);
      check("inflight_result", result, 32'd1000);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_result", result, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst%0d_valid", cyc), {31'd0, out_valid}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
